// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared definitions for the fetch-stage hazard sequencer: FSM state encoding and
// the register-zero index.
package fetch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MDBUSY  = 2'd1,
        ST_HALT    = 2'd2,
        ST_ILLEGAL = 2'd3
    } ctrl_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fetch_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID source registers and the
// destination of a load in EX. Writes to the zero register never create a hazard.
module hazard_detect
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] dx_rd,
    input  logic              dx_mem_read,
    output logic              ldu
);

    always_comb begin
        ldu = dx_mem_read && (dx_rd != REG_AW'(REG_ZERO)) &&
              ((dx_rd == id_rs) || (id_uses_rt && (dx_rd == id_rt)));
    end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage pipeline sequencer: branch/jump flushes, load-use stalls, mul/div
// occupancy and halt. Optional perf counters are built when PERF_CNT_EN is defined.
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] dx_rd,
    input  logic              dx_mem_read,
    input  logic              dx_muldiv,
    input  logic              ex_branch_tkn,
    input  logic              halt_req,
    input  logic              resume,
    output logic              fetch_en,
    output logic              fd_hold,
    output logic              fd_flush,
    output logic              dx_bubble,
    output logic [1:0]        ctrl_state
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int unsigned MDW = $clog2(MULDIV_LAT);

    if (MULDIV_LAT < 2 || CNT_W < 1) begin : g_param_check
        $error("fetch_hazard_ctrl: MULDIV_LAT must be >= 2 and CNT_W >= 1");
    end

    ctrl_state_t    state;
    logic [MDW-1:0] mdcnt;
    logic           halt_pend;
    logic           ldu;
    logic           hold_raw;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .dx_rd       (dx_rd),
        .dx_mem_read (dx_mem_read),
        .ldu         (ldu)
    );

    always_comb begin
        fetch_en  = 1'b0;
        hold_raw  = 1'b0;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        if (!rst) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_branch_tkn) begin
                        fetch_en  = 1'b1;
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (dx_muldiv) begin
                        hold_raw  = 1'b1;
                    end else if (ldu) begin
                        hold_raw  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (id_jump) begin
                        fetch_en  = 1'b1;
                        fd_flush  = 1'b1;
                    end else if (halt_req) begin
                        hold_raw  = 1'b1;
                    end else begin
                        fetch_en  = 1'b1;
                    end
                end
                ST_MDBUSY: hold_raw = 1'b1;
                ST_HALT: begin
                    hold_raw  = 1'b1;
                    dx_bubble = 1'b1;
                end
                default: hold_raw = 1'b1;
            endcase
        end
        fd_hold = hold_raw & ~fd_flush;
    end

    assign ctrl_state = state;

    // A halt request seen on the final busy cycle still diverts to HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            mdcnt     <= '0;
            halt_pend <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!ex_branch_tkn) begin
                        if (dx_muldiv) begin
                            mdcnt <= MDW'(MULDIV_LAT - 1);
                            state <= ST_MDBUSY;
                        end else if (!ldu && !id_jump && halt_req) begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_MDBUSY: begin
                    mdcnt <= mdcnt - MDW'(1);
                    if (halt_req) halt_pend <= 1'b1;
                    if (mdcnt == MDW'(1)) begin
                        state <= (halt_pend || halt_req) ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state     <= ST_RUN;
                        halt_pend <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    mdcnt     <= '0;
                    halt_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!fetch_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (fd_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
